game_seq_ctrl: RTL and testbench

Game sequencer for the 640x480 VGA game. It debounces the player push-button, runs an IDLE/PLAY/OVER state machine, keeps a BCD score (0-999) and a BCD countdown timer in seconds, and generates a per-frame tick from the VGA counters. Its BCD outputs drive the seven-segment display renderers. Its state and blink outputs select the colour layers in the top-level RGB mux.

---
 rtl/game_seq_ctrl_if.sv | 21 ++
 rtl/game_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_game_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_seq_ctrl_if.sv
// game_seq_ctrl_if: button/VGA inputs and display/state outputs of the game sequencer.
// master drives the button and VGA counters; slave is the sequencer.
interface game_seq_ctrl_if;
    logic        nPBTON;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [3:0]  score_u, score_t, score_h;
    logic [3:0]  time_u, time_t;
    logic        blink;
    logic [3:0]  hi_u, hi_t, hi_h;
    modport master (
        output nPBTON, hcount, vcount,
        input  frame_tick, game_state, score_u, score_t, score_h, time_u, time_t, blink, hi_u, hi_t, hi_h
    );
    modport slave (
        input  nPBTON, hcount, vcount,
        output frame_tick, game_state, score_u, score_t, score_h, time_u, time_t, blink, hi_u, hi_t, hi_h
    );
endinterface

// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: debounced button, IDLE/PLAY/OVER FSM, BCD score and countdown, frame tick.
// Define HIGH_SCORE_EN to build the best-score register behind hi_u/hi_t/hi_h.
module game_seq_ctrl #(
    parameter int FPGAFREQ     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int GAME_SECS    = 60,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 32
) (
    input logic CLK,
    input logic nRST,
    game_seq_ctrl_if.slave bus
);
    localparam int DW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SW = FPGAFREQ > 1 ? $clog2(FPGAFREQ) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] GAME_BCD = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    state_t          state, state_n;
    logic [1:0]      sync;
    logic            lvl, acc, press, ft, sec_tick, blink, blink_n;
    logic [DW-1:0]   db_cnt;
    logic [SW-1:0]   sec_cnt;
    logic [BW-1:0]   bc, bc_n;
    logic [11:0]     score, score_n;
    logic [7:0]      tm, tm_n;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] u, t, h;
        u = v[3:0] == 4'd9 ? 4'd0 : v[3:0] + 4'd1;
        t = v[3:0] != 4'd9 ? v[7:4] : v[7:4] == 4'd9 ? 4'd0 : v[7:4] + 4'd1;
        h = v[7:0] != 8'h99 ? v[11:8] : v[11:8] == 4'd9 ? 4'd0 : v[11:8] + 4'd1;
        return {h, t, u};
    endfunction

    assign lvl      = ~sync[1];
    assign sec_tick = state == PLAY && sec_cnt == SW'(FPGAFREQ - 1);

    // counter runs only while the synchronized level disagrees with the accepted one
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync    <= 2'b11;
            acc     <= 1'b0;
            press   <= 1'b0;
            db_cnt  <= '0;
            ft      <= 1'b0;
            sec_cnt <= '0;
        end else begin
            sync  <= {sync[0], bus.nPBTON};
            press <= 1'b0;
            if (lvl == acc) db_cnt <= '0;
            else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                acc    <= lvl;
                press  <= lvl;
                db_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
            ft      <= bus.hcount == 11'd0 && bus.vcount == 11'(V_ACTIVE);
            sec_cnt <= (state != PLAY || sec_tick) ? '0 : sec_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            score <= '0;
            tm    <= '0;
            blink <= 1'b1;
            bc    <= '0;
        end else begin
            state <= state_n;
            score <= score_n;
            tm    <= tm_n;
            blink <= blink_n;
            bc    <= bc_n;
        end
    end

    always_comb begin
        state_n = state;
        score_n = score;
        tm_n    = tm;
        blink_n = blink;
        bc_n    = bc;
        case (state)
            IDLE: if (press) begin
                state_n = PLAY;
                score_n = '0;
                tm_n    = GAME_BCD;
            end
            PLAY: begin
                blink_n = 1'b1;
                bc_n    = '0;
                if (press) score_n = bcd_inc(score);
                if (sec_tick) begin
                    tm_n    = tm[3:0] == 4'd0 ? {tm[7:4] - 4'd1, 4'd9} : {tm[7:4], tm[3:0] - 4'd1};
                    state_n = tm == 8'h01 ? OVER : PLAY;
                end
            end
            OVER: begin
                if (ft) begin
                    bc_n    = bc == BW'(BLINK_FRAMES - 1) ? '0 : bc + 1'b1;
                    blink_n = bc == BW'(BLINK_FRAMES - 1) ? ~blink : blink;
                end
                if (press) begin
                    state_n = IDLE;
                    blink_n = 1'b1;
                    bc_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef HIGH_SCORE_EN
    logic        over_q;
    logic [11:0] hi;
    // packed BCD orders the same as the binary value, so a plain compare works
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            over_q <= 1'b0;
            hi     <= '0;
        end else begin
            over_q <= state == PLAY && state_n == OVER;
            if (over_q && score > hi) hi <= score;
        end
    end
    assign {bus.hi_h, bus.hi_t, bus.hi_u} = hi;
`else
    assign {bus.hi_h, bus.hi_t, bus.hi_u} = '0;
`endif

    assign bus.frame_tick = ft;
    assign bus.game_state = state;
    assign {bus.score_h, bus.score_t, bus.score_u} = score;
    assign {bus.time_t, bus.time_u} = tm;
    assign bus.blink = blink;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: directed bench for game_seq_ctrl with three instances differing in second-tick rate.
// a: fast timer and blink, b: scoring and coincident final press, c: score wrap and mid-game reset.
module tb_game_seq_ctrl;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [2:0]  pb = 3'b111;
    logic [10:0] h = 11'd0;
    logic [10:0] v = 11'd0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    // small raster: 10 columns x 8 lines, frame tick once per 80 cycles
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        h   <= (h == 11'd9) ? 11'd0 : h + 11'd1;
        if (h == 11'd9) v <= (v == 11'd7) ? 11'd0 : v + 11'd1;
    end

    game_seq_ctrl_if bus_a ();
    game_seq_ctrl_if bus_b ();
    game_seq_ctrl_if bus_c ();

    assign bus_a.nPBTON = pb[0];
    assign bus_a.hcount = h;
    assign bus_a.vcount = v;
    assign bus_b.nPBTON = pb[1];
    assign bus_b.hcount = h;
    assign bus_b.vcount = v;
    assign bus_c.nPBTON = pb[2];
    assign bus_c.hcount = h;
    assign bus_c.vcount = v;

    game_seq_ctrl #(.FPGAFREQ(100), .DEBOUNCE_CYC(16), .GAME_SECS(3), .V_ACTIVE(5), .BLINK_FRAMES(2))
        dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a));
    game_seq_ctrl #(.FPGAFREQ(1000), .DEBOUNCE_CYC(16), .GAME_SECS(3), .V_ACTIVE(5), .BLINK_FRAMES(2))
        dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b));
    game_seq_ctrl #(.FPGAFREQ(100000), .DEBOUNCE_CYC(16), .GAME_SECS(3), .V_ACTIVE(5), .BLINK_FRAMES(2))
        dut_c (.CLK(CLK), .nRST(nRST), .bus(bus_c));

    function automatic logic [1:0] st(input int i);
        return i == 0 ? bus_a.game_state : i == 1 ? bus_b.game_state : bus_c.game_state;
    endfunction

    function automatic logic [11:0] sc(input int i);
        return i == 0 ? {bus_a.score_h, bus_a.score_t, bus_a.score_u} :
               i == 1 ? {bus_b.score_h, bus_b.score_t, bus_b.score_u} :
                        {bus_c.score_h, bus_c.score_t, bus_c.score_u};
    endfunction

    function automatic logic [7:0] tm(input int i);
        return i == 0 ? {bus_a.time_t, bus_a.time_u} :
               i == 1 ? {bus_b.time_t, bus_b.time_u} : {bus_c.time_t, bus_c.time_u};
    endfunction

    function automatic logic [11:0] hi(input int i);
        return i == 0 ? {bus_a.hi_h, bus_a.hi_t, bus_a.hi_u} :
               i == 1 ? {bus_b.hi_h, bus_b.hi_t, bus_b.hi_u} : {bus_c.hi_h, bus_c.hi_t, bus_c.hi_u};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge CLK);
        check("schedule", cyc, t);
    endtask

    task automatic press(input int i, input int lo, input int hold);
        pb[i] = 1'b0;
        repeat (lo) @(negedge CLK);
        pb[i] = 1'b1;
        repeat (hold) @(negedge CLK);
    endtask

    // holds the button 40 cycles, reports the cycle PLAY appeared and the press-to-state latency
    task automatic start(input int i, output int p, output int l);
        int m;
        m = cyc;
        p = -1;
        pb[i] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (p < 0 && st(i) == 2'd1) p = cyc;
        end
        pb[i] = 1'b1;
        repeat (20) @(negedge CLK);
        check("start_seen", p >= 0, 1);
        l = p - m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pa, la, pbt, lb, pc, lc, t;
        logic [11:0] hi_exp;
        logic bexp [3];
`ifdef HIGH_SCORE_EN
        hi_exp = 12'h042;
`else
        hi_exp = 12'h000;
`endif
        bexp = '{1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge CLK);
        check("rst_state", st(0), 2'd0);
        check("rst_score", sc(0), 12'h000);
        check("rst_time", tm(0), 8'h00);
        check("rst_blink", bus_a.blink, 1'b1);
        check("rst_ftick", bus_a.frame_tick, 1'b0);
        check("rst_hi", hi(0), 12'h000);
        nRST = 1'b1;

        t = 0;
        repeat (240) begin
            @(negedge CLK);
            if (bus_a.frame_tick) begin
                t++;
                check("ftick_pos", {h, v}, {11'd1, 11'd5});
            end
        end
        check("ftick_count", t, 3);
        check("idle_state", st(0), 2'd0);

        pb[0] = 1'b0;
        repeat (10) @(negedge CLK);
        pb[0] = 1'b1;
        repeat (10) @(negedge CLK);
        check("bounce_idle", st(0), 2'd0);
        start(0, pa, la);
        check("start_state", st(0), 2'd1);
        check("start_time", tm(0), 8'h03);
        check("start_score", sc(0), 12'h000);
        press(0, 20, 20);
        check("a_score1", sc(0), 12'h001);
        wait_to(pa + 99);
        check("time_03", tm(0), 8'h03);
        wait_to(pa + 100);
        check("time_02", tm(0), 8'h02);
        wait_to(pa + 200);
        check("time_01", tm(0), 8'h01);
        wait_to(pa + 299);
        check("pre_over_state", st(0), 2'd1);
        wait_to(pa + 300);
        check("over_state", st(0), 2'd2);
        check("over_time", tm(0), 8'h00);
        check("over_score", sc(0), 12'h001);
        check("over_blink", bus_a.blink, 1'b1);

        foreach (bexp[k]) begin
            t = 0;
            while (!bus_a.frame_tick && t < 200) begin
                @(negedge CLK);
                t++;
            end
            check("blink_wait", t < 200, 1);
            @(negedge CLK);
            check("blink", bus_a.blink, bexp[k]);
        end
        press(0, 20, 20);
        check("back_idle", st(0), 2'd0);
        check("idle_blink", bus_a.blink, 1'b1);
        check("idle_score_held", sc(0), 12'h001);

        start(1, pbt, lb);
        repeat (12) press(1, 25, 25);
        check("score_012", sc(1), 12'h012);
        repeat (29) press(1, 20, 20);
        check("score_041", sc(1), 12'h041);
        wait_to(pbt + 3000 - lb);
        pb[1] = 1'b0;
        wait_to(pbt + 2999);
        check("coin_pre_state", st(1), 2'd1);
        check("coin_pre_score", sc(1), 12'h041);
        check("coin_pre_time", tm(1), 8'h01);
        wait_to(pbt + 3000);
        check("coin_state", st(1), 2'd2);
        check("coin_score", sc(1), 12'h042);
        check("coin_time", tm(1), 8'h00);
        wait_to(pbt + 3003);
        check("coin_stays_over", st(1), 2'd2);
        check("hi_042", hi(1), hi_exp);
        wait_to(pbt + 3020);
        pb[1] = 1'b1;
        repeat (25) @(negedge CLK);
        press(1, 25, 25);
        check("b_idle", st(1), 2'd0);
        check("b_score_held", sc(1), 12'h042);
        start(1, pbt, lb);
        check("b_restart_score", sc(1), 12'h000);
        repeat (10) press(1, 25, 25);
        t = 0;
        while (st(1) != 2'd2 && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        check("b_round2_over", st(1), 2'd2);
        check("b_round2_score", sc(1), 12'h010);
        repeat (3) @(negedge CLK);
        check("hi_kept", hi(1), hi_exp);

        start(2, pc, lc);
        repeat (999) press(2, 20, 20);
        check("score_999", sc(2), 12'h999);
        press(2, 20, 20);
        check("score_wrap", sc(2), 12'h000);
        press(2, 20, 20);
        check("score_001", sc(2), 12'h001);
        check("c_still_play", st(2), 2'd1);
        pb[2] = 1'b0;
        repeat (10) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("async_rst_state", st(2), 2'd0);
        check("async_rst_score", sc(2), 12'h000);
        check("async_rst_time", tm(2), 8'h00);
        pb[2] = 1'b1;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (40) @(negedge CLK);
        check("no_pending_state", st(2), 2'd0);
        check("no_pending_score", sc(2), 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
